// File: rtl/regfile_sb.sv
// regfile_sb: 32 x W register file with a busy scoreboard and write-first bypass.
// Ports:
//   clk_in, reset        clock and synchronous active-high reset
//   rd_addr_in/rd_*_out  NUM_READ read ports: data and busy (combinational)
//   wr_*_in              NUM_WRITE writeback ports (enable, address, data)
//   issue_*_in/_out      mark a destination busy; stall on a WAW hazard
module regfile_sb #(
    parameter int REG_DATA_WIDTH_POW = 6,
    parameter int NUM_READ           = 2,
    parameter int NUM_WRITE          = 1,
    parameter int REG_COUNT          = 32,
    localparam int W = 1 << REG_DATA_WIDTH_POW
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic [NUM_READ*5-1:0]  rd_addr_in,
    output logic [NUM_READ*W-1:0]  rd_data_out,
    output logic [NUM_READ-1:0]    rd_busy_out,
    input  logic [NUM_WRITE-1:0]   wr_en_in,
    input  logic [NUM_WRITE*5-1:0] wr_addr_in,
    input  logic [NUM_WRITE*W-1:0] wr_data_in,
    input  logic                   issue_en_in,
    input  logic [4:0]             issue_rd_in,
    output logic                   issue_stall_out
);

    logic [W-1:0]           r_data [REG_COUNT];
    logic [REG_COUNT-1:0]   r_busy;

    // Per-register view of this cycle's effective writes.
    logic [REG_COUNT-1:0]   w_hit;
    logic [W-1:0]           w_wdata [REG_COUNT];
    logic                   w_issue_ok;

    // Ascending scan: a later (higher-index) port overrides earlier ones.
    always_comb begin
        w_hit = '0;
        for (int r = 0; r < REG_COUNT; r++) begin
            w_wdata[r] = '0;
        end
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (wr_en_in[j] && wr_addr_in[5*j +: 5] != 5'd0) begin
                w_hit[wr_addr_in[5*j +: 5]]   = 1'b1;
                w_wdata[wr_addr_in[5*j +: 5]] = wr_data_in[W*j +: W];
            end
        end
    end

    // Bypass and busy are suppressed while reset is held.
    always_comb begin
        rd_data_out = '0;
        rd_busy_out = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            if (rd_addr_in[5*k +: 5] != 5'd0) begin
                if (!reset && w_hit[rd_addr_in[5*k +: 5]]) begin
                    rd_data_out[W*k +: W] = w_wdata[rd_addr_in[5*k +: 5]];
                end else begin
                    rd_data_out[W*k +: W] = r_data[rd_addr_in[5*k +: 5]];
                end
                rd_busy_out[k] = !reset
                               && r_busy[rd_addr_in[5*k +: 5]]
                               && !w_hit[rd_addr_in[5*k +: 5]];
            end
        end
    end

    // A writeback landing this cycle resolves the WAW hazard immediately.
    assign issue_stall_out = !reset && issue_en_in
                           && issue_rd_in != 5'd0
                           && r_busy[issue_rd_in]
                           && !w_hit[issue_rd_in];

    assign w_issue_ok = !reset && issue_en_in
                      && issue_rd_in != 5'd0
                      && !issue_stall_out;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                r_data[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int r = 1; r < REG_COUNT; r++) begin
                if (w_hit[r]) begin
                    r_data[r] <= w_wdata[r];
                end
                // Issue set takes priority over writeback clear.
                if (w_issue_ok && issue_rd_in == 5'(r)) begin
                    r_busy[r] <= 1'b1;
                end else if (w_hit[r]) begin
                    r_busy[r] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus randomized run against a
// reference model of the register file, scoreboard and bypass rules.
module tb_regfile_sb;

    localparam int NR = 4;
    localparam int NW = 3;
    localparam int W  = 64;

    logic              clk_in = 1'b0;
    logic              reset;
    logic [NR*5-1:0]   rd_addr_in;
    logic [NR*W-1:0]   rd_data_out;
    logic [NR-1:0]     rd_busy_out;
    logic [NW-1:0]     wr_en_in;
    logic [NW*5-1:0]   wr_addr_in;
    logic [NW*W-1:0]   wr_data_in;
    logic              issue_en_in;
    logic [4:0]        issue_rd_in;
    logic              issue_stall_out;

    logic [4:0]        ra [NR];
    logic [4:0]        wa [NW];
    logic [W-1:0]      wd [NW];

    logic [W-1:0]      m_data [32];
    logic              m_busy [32];

    int checks   = 0;
    int failures = 0;
    logic last_stall = 1'b0;

    always #5 clk_in = ~clk_in;

    for (genvar g = 0; g < NR; g++) begin : g_rd
        assign rd_addr_in[5*g +: 5] = ra[g];
    end
    for (genvar g = 0; g < NW; g++) begin : g_wr
        assign wr_addr_in[5*g +: 5] = wa[g];
        assign wr_data_in[W*g +: W] = wd[g];
    end

    regfile_sb #(
        .REG_DATA_WIDTH_POW(6),
        .NUM_READ(NR),
        .NUM_WRITE(NW)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .rd_addr_in(rd_addr_in),
        .rd_data_out(rd_data_out),
        .rd_busy_out(rd_busy_out),
        .wr_en_in(wr_en_in),
        .wr_addr_in(wr_addr_in),
        .wr_data_in(wr_data_in),
        .issue_en_in(issue_en_in),
        .issue_rd_in(issue_rd_in),
        .issue_stall_out(issue_stall_out)
    );

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Last effective write to a nonzero address wins; reset disables bypass.
    function automatic logic [W-1:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return '0;
        if (!reset) begin
            for (int j = NW - 1; j >= 0; j--) begin
                if (wr_en_in[j] && wa[j] == a) return wd[j];
            end
        end
        return m_data[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0 || reset) return 1'b0;
        for (int j = 0; j < NW; j++) begin
            if (wr_en_in[j] && wa[j] == a) return 1'b0;
        end
        return m_busy[a];
    endfunction

    function automatic logic exp_stall();
        if (reset || !issue_en_in || issue_rd_in == 5'd0) return 1'b0;
        return exp_busy(issue_rd_in);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_data[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Check outputs against the model, advance the model and one clock.
    task automatic step();
        logic st;
        #1;
        st = exp_stall();
        for (int k = 0; k < NR; k++) begin
            chk($sformatf("data%0d", k), rd_data_out[W*k +: W], exp_data(ra[k]));
            chk($sformatf("busy%0d", k), W'(rd_busy_out[k]), W'(exp_busy(ra[k])));
        end
        chk("stall", W'(issue_stall_out), W'(st));
        last_stall = st;
        if (reset) begin
            model_reset();
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (wr_en_in[j] && wa[j] != 5'd0) begin
                    m_data[wa[j]] = wd[j];
                    m_busy[wa[j]] = 1'b0;
                end
            end
            if (issue_en_in && issue_rd_in != 5'd0 && !st)
                m_busy[issue_rd_in] = 1'b1;
        end
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    typedef struct {
        int rst; int we;
        int wa0; longint unsigned wd0;
        int wa1; longint unsigned wd1;
        int ie; int ird; int ra0; int ra1;
        longint unsigned d0; int b0;
        longint unsigned d1; int b1;
        int st;
    } vec_t;

    vec_t tbl [19];

    initial begin
        // rst we wa0 wd0 wa1 wd1 ie ird ra0 ra1 d0 b0 d1 b1 st
        tbl[0]  = '{0,0,0,0,0,0,0,0,5,31,0,0,0,0,0};
        tbl[1]  = '{0,1,5,64'hDEADBEEF,0,0,0,0,5,31,64'hDEADBEEF,0,0,0,0};
        tbl[2]  = '{0,0,0,0,0,0,0,0,5,31,64'hDEADBEEF,0,0,0,0};
        tbl[3]  = '{0,1,0,64'h1234,0,0,1,0,0,0,0,0,0,0,0};
        tbl[4]  = '{0,0,0,0,0,0,1,0,0,5,0,0,64'hDEADBEEF,0,0};
        tbl[5]  = '{0,3,7,64'h11,7,64'h22,0,0,7,7,64'h22,0,64'h22,0,0};
        tbl[6]  = '{0,0,0,0,0,0,0,0,7,0,64'h22,0,0,0,0};
        tbl[7]  = '{0,0,0,0,0,0,1,9,9,7,0,0,64'h22,0,0};
        tbl[8]  = '{0,0,0,0,0,0,1,9,9,7,0,1,64'h22,0,1};
        tbl[9]  = '{0,1,9,64'h55,0,0,1,9,9,9,64'h55,0,64'h55,0,0};
        tbl[10] = '{0,0,0,0,0,0,0,0,9,0,64'h55,1,0,0,0};
        tbl[11] = '{0,0,0,0,0,0,1,3,3,9,0,0,64'h55,1,0};
        tbl[12] = '{0,1,3,64'hAA,0,0,0,0,3,9,64'hAA,0,64'h55,1,0};
        tbl[13] = '{0,1,3,64'hBB,0,0,0,0,3,9,64'hBB,0,64'h55,1,0};
        tbl[14] = '{1,1,4,64'h99,0,0,1,6,4,9,0,0,64'h55,0,0};
        tbl[15] = '{0,0,0,0,0,0,0,0,3,4,0,0,0,0,0};
        tbl[16] = '{0,0,0,0,0,0,0,0,6,9,0,0,0,0,0};
        tbl[17] = '{0,0,0,0,0,0,1,6,6,9,0,0,0,0,0};
        tbl[18] = '{0,0,0,0,0,0,1,6,6,9,0,1,0,0,1};

        reset       = 1'b1;
        wr_en_in    = '0;
        issue_en_in = 1'b0;
        issue_rd_in = '0;
        for (int k = 0; k < NR; k++) ra[k] = '0;
        for (int j = 0; j < NW; j++) begin
            wa[j] = '0;
            wd[j] = '0;
        end
        @(posedge clk_in);
        @(negedge clk_in);
        model_reset();

        for (int i = 0; i < 19; i++) begin
            reset       = tbl[i].rst[0];
            wr_en_in    = NW'(tbl[i].we);
            wa[0]       = 5'(tbl[i].wa0);
            wd[0]       = tbl[i].wd0;
            wa[1]       = 5'(tbl[i].wa1);
            wd[1]       = tbl[i].wd1;
            wa[2]       = '0;
            wd[2]       = '0;
            issue_en_in = tbl[i].ie[0];
            issue_rd_in = 5'(tbl[i].ird);
            ra[0]       = 5'(tbl[i].ra0);
            ra[1]       = 5'(tbl[i].ra1);
            ra[2]       = ra[0];
            ra[3]       = ra[1];
            #1;
            chk($sformatf("row%0d_d0", i), rd_data_out[0 +: W], tbl[i].d0);
            chk($sformatf("row%0d_b0", i), W'(rd_busy_out[0]), W'(tbl[i].b0));
            chk($sformatf("row%0d_d1", i), rd_data_out[W +: W], tbl[i].d1);
            chk($sformatf("row%0d_b1", i), W'(rd_busy_out[1]), W'(tbl[i].b1));
            chk($sformatf("row%0d_st", i), W'(issue_stall_out), W'(tbl[i].st));
            step();
        end

        for (int c = 0; c < 10000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int j = 0; j < NW; j++) begin
                wr_en_in[j] = 1'($urandom_range(0, 1));
                wa[j]       = rnd_addr();
                wd[j]       = {$urandom, $urandom};
            end
            // A stalled requester usually holds its request.
            if (!(last_stall && $urandom_range(0, 3) != 0)) begin
                issue_en_in = 1'($urandom_range(0, 1));
                issue_rd_in = rnd_addr();
            end
            for (int k = 0; k < NR; k++) ra[k] = rnd_addr();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
